// File: rtl/shifter_pipe.sv
// shifter_pipe -- pipelined ARM-style barrel shifter producing shifter_operand
// and shifter carry-out. It handles both immediate and register-specified
// shift amounts, with full Rs[7:0] semantics in register mode.
//
// Parameters
//   WIDTH  : operand width (power of two, >= 8)
//   STAGES : 1 = decode and shift in one stage; 2 = stage A decodes, stage B shifts
//   TAG_W  : sideband tag width, passed through unchanged
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   in_valid/ready   : input handshake. in_ready is combinational from out_ready.
//   shift_in         : operand (Rm)
//   shift_type       : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   reg_mode         : 0 = amount from shift_imm, 1 = amount from shift_reg (Rs[7:0])
//   carry_in         : current C flag
//   in_tag / out_tag : sideband tag
//   out_valid/ready  : output handshake. Outputs are held while stalled.
//   shifter_operand, shift_carry_out : result
//
// Optional feature, macro SHIFTER_PIPE_FLAGS_EN
//   Adds result_zero / result_neg, which are registered with the result.
module shifter_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         shift_in,
  input  logic [1:0]               shift_type,
  input  logic                     reg_mode,
  input  logic [$clog2(WIDTH)-1:0] shift_imm,
  input  logic [7:0]               shift_reg,
  input  logic                     carry_in,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         shifter_operand,
  output logic                     shift_carry_out,
  output logic [TAG_W-1:0]         out_tag
`ifdef SHIFTER_PIPE_FLAGS_EN
  ,
  output logic                     result_zero,
  output logic                     result_neg
`endif
);

  localparam int AW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    C_NORMAL, C_ZERO, C_SIGNFILL, C_PASS, C_RRX
  } code_e;

  // Decoded beat. 'sc' is the carry for every special code, so the shift
  // stage only has to derive the carry for normal shifts (1..WIDTH-1).
  typedef struct packed {
    logic [WIDTH-1:0] opnd;
    logic [1:0]       typ;
    logic [AW-1:0]    amt;
    code_e            code;
    logic             cin;
    logic             sc;
    logic [TAG_W-1:0] tag;
  } dec_t;

  dec_t          dec_now, b_src;
  logic          b_src_vld, b_adv, b_vld;
  logic [AW-1:0] s_lo;
  int            s_int;

  // ---------------- decode ----------------
  always_comb begin
    s_int        = int'(shift_reg);
    // For LSL/LSR/ASR with S < WIDTH this is S itself. For ROR it is S mod WIDTH.
    s_lo         = AW'(shift_reg);
    dec_now.opnd = shift_in;
    dec_now.typ  = shift_type;
    dec_now.amt  = reg_mode ? s_lo : shift_imm;
    dec_now.code = C_NORMAL;
    dec_now.cin  = carry_in;
    dec_now.sc   = carry_in;
    dec_now.tag  = in_tag;
    if (!reg_mode) begin
      // An immediate of 0 encodes a special case for every type.
      if (shift_imm == '0) begin
        unique case (shift_type)
          2'b00: dec_now.code = C_PASS;
          2'b01: begin dec_now.code = C_ZERO;     dec_now.sc = shift_in[WIDTH-1]; end
          2'b10: begin dec_now.code = C_SIGNFILL; dec_now.sc = shift_in[WIDTH-1]; end
          default: begin dec_now.code = C_RRX;    dec_now.sc = shift_in[0]; end
        endcase
      end
    end else if (shift_reg == 8'd0) begin
      dec_now.code = C_PASS;
    end else begin
      unique case (shift_type)
        2'b00: begin
          if (s_int == WIDTH)     begin dec_now.code = C_ZERO; dec_now.sc = shift_in[0]; end
          else if (s_int > WIDTH) begin dec_now.code = C_ZERO; dec_now.sc = 1'b0; end
        end
        2'b01: begin
          if (s_int == WIDTH)     begin dec_now.code = C_ZERO; dec_now.sc = shift_in[WIDTH-1]; end
          else if (s_int > WIDTH) begin dec_now.code = C_ZERO; dec_now.sc = 1'b0; end
        end
        2'b10: begin
          if (s_int >= WIDTH) begin dec_now.code = C_SIGNFILL; dec_now.sc = shift_in[WIDTH-1]; end
        end
        default: begin
          // A rotate by a nonzero multiple of WIDTH leaves the value unchanged.
          // The carry is then the msb.
          if (s_lo == '0) begin dec_now.code = C_PASS; dec_now.sc = shift_in[WIDTH-1]; end
        end
      endcase
    end
  end

  // ---------------- shift ----------------
  logic [WIDTH-1:0] b_res;
  logic             b_c;
  logic [AW-1:0]    ix_l, ix_r;

  always_comb begin
    // Only used for normal codes, where 1 <= amt <= WIDTH-1. Both indexes are then in range.
    ix_l  = AW'(0) - b_src.amt;   // WIDTH - amt
    ix_r  = b_src.amt - AW'(1);   // amt - 1
    b_res = b_src.opnd;
    b_c   = b_src.sc;
    unique case (b_src.code)
      C_ZERO:     b_res = '0;
      C_SIGNFILL: b_res = {WIDTH{b_src.opnd[WIDTH-1]}};
      C_RRX:      b_res = {b_src.cin, b_src.opnd[WIDTH-1:1]};
      C_NORMAL: begin
        unique case (b_src.typ)
          2'b00: begin b_res = b_src.opnd << b_src.amt;            b_c = b_src.opnd[ix_l]; end
          2'b01: begin b_res = b_src.opnd >> b_src.amt;            b_c = b_src.opnd[ix_r]; end
          2'b10: begin b_res = $signed(b_src.opnd) >>> b_src.amt;  b_c = b_src.opnd[ix_r]; end
          default: begin
            b_res = (b_src.opnd >> b_src.amt) | (b_src.opnd << ix_l);
            b_c   = b_src.opnd[ix_r];
          end
        endcase
      end
      default: ;  // C_PASS: operand and sc unchanged
    endcase
  end

  // ---------------- pipeline control ----------------
  assign b_adv = !b_vld || out_ready;

  generate
    if (STAGES == 2) begin : g_two
      dec_t a_q;
      logic a_vld, a_adv;
      assign a_adv     = !a_vld || b_adv;
      assign in_ready  = a_adv;
      assign b_src     = a_q;
      assign b_src_vld = a_vld;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_vld <= 1'b0;
          a_q   <= '0;
        end else if (a_adv) begin
          a_vld <= in_valid;
          if (in_valid) a_q <= dec_now;
        end
      end
    end else begin : g_one
      assign in_ready  = b_adv;
      assign b_src     = dec_now;
      assign b_src_vld = in_valid;
    end
  endgenerate

  // Final stage. Data only moves when the stage advances, so a stall holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld           <= 1'b0;
      shifter_operand <= '0;
      shift_carry_out <= 1'b0;
      out_tag         <= '0;
`ifdef SHIFTER_PIPE_FLAGS_EN
      result_zero     <= 1'b0;
      result_neg      <= 1'b0;
`endif
    end else if (b_adv) begin
      b_vld <= b_src_vld;
      if (b_src_vld) begin
        shifter_operand <= b_res;
        shift_carry_out <= b_c;
        out_tag         <= b_src.tag;
`ifdef SHIFTER_PIPE_FLAGS_EN
        result_zero     <= (b_res == '0);
        result_neg      <= b_res[WIDTH-1];
`endif
      end
    end
  end

  assign out_valid = b_vld;

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle operand shifter in the CPU execute path.
- Computes ARM-style shifter_operand and shifter carry-out for both immediate-specified and register-specified shift amounts (full 8-bit Rs[7:0] semantics).
- Uses valid/ready handshakes on both sides so the execute stage can stall it.
- Carries a tag through the pipe so the result can be matched to its instruction.

Parameters:
- WIDTH, 32: operand width. Power of two, ≥ 8.
- STAGES, 2: pipeline depth, 1 or 2. With 1, decode and shift happen in one stage. With 2, stage A decodes and stage B shifts.
- TAG_W, 4: width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- shift_in  in  WIDTH  operand to shift (Rm)
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- reg_mode  in  1  0 = immediate amount, 1 = register amount
- shift_imm  in  $clog2(WIDTH)  immediate amount, used when reg_mode=0
- shift_reg  in  8  register amount Rs[7:0], used when reg_mode=1
- carry_in  in  1  current C flag
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- shifter_operand  out  WIDTH  shifted result
- shift_carry_out  out  1  shifter carry
- out_tag  out  TAG_W  tag of the result beat

Behaviour:
- Handshake rules:
  - A transfer occurs when valid && ready on that side.
  - A stage loads when it is empty, or when it is full and its downstream accepts in the same cycle.
  - in_ready = first stage empty OR first stage advancing. in_ready is combinational from out_ready.
  - While out_valid=1 && out_ready=0, shifter_operand, shift_carry_out and out_tag are held stable.
  - Full throughput is 1 beat/cycle. Latency from accepted input to out_valid is STAGES cycles.
- Reset:
  - All stage valid bits clear, so out_valid=0.
  - shifter_operand=0, shift_carry_out=0, out_tag=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - rst mid-operation discards all in-flight beats; nothing is emitted for them.
- Immediate mode (reg_mode=0), where N = shift_imm:
  - LSL: N=0 gives result=in, C=carry_in. Otherwise result=in<<N, C=in[WIDTH-N].
  - LSR: N=0 encodes LSR #WIDTH, giving result=0, C=in[WIDTH-1]. Otherwise result=in>>N, C=in[N-1].
  - ASR: N=0 encodes ASR #WIDTH, giving result=all copies of in[WIDTH-1], C=in[WIDTH-1]. Otherwise arithmetic shift, C=in[N-1].
  - ROR: N=0 encodes RRX, giving result={carry_in, in[WIDTH-1:1]}, C=in[0]. Otherwise rotate right by N, C=in[N-1].
- Register mode (reg_mode=1), where S = shift_reg, 0..255:
  - S=0, any type: result=in, C=carry_in.
  - LSL: 0<S<WIDTH gives in<<S, C=in[WIDTH-S]. S=WIDTH gives 0, C=in[0]. S>WIDTH gives 0, C=0.
  - LSR: 0<S<WIDTH gives in>>S, C=in[S-1]. S=WIDTH gives 0, C=in[WIDTH-1]. S>WIDTH gives 0, C=0.
  - ASR: 0<S<WIDTH gives arithmetic shift, C=in[S-1]. S≥WIDTH gives sign fill, C=in[WIDTH-1].
  - ROR: let R = S mod WIDTH. R=0 with S≠0 gives result=in, C=in[WIDTH-1]. Otherwise rotate right by R, C=in[R-1].
- Implementation and width rules:
  - No out-of-range bit selects. All indexes are computed modulo WIDTH, with special cases decoded explicitly.
  - With STAGES=2, stage A registers: operand, type, effective amount ($clog2(WIDTH) bits), special-case code (NORMAL, ZERO, SIGNFILL, PASS, RRX), carry_in, tag.
  - With STAGES=2, stage B computes and registers result and carry.
  - Simultaneous in and out transfers on a full pipe are legal and lose no beat.

Optional Feature:
- Macro SHIFTER_PIPE_FLAGS_EN.
- When defined:
  - Adds outputs result_zero (1) and result_neg (1), registered in the final stage alongside shifter_operand.
  - result_zero = (shifter_operand == 0); result_neg = shifter_operand[WIDTH-1].
  - Both reset to 0 and are held during a stall.
- When undefined: the ports do not exist and no flag logic is synthesised.

Test Plan:
- Latency: WIDTH=32, STAGES=2, imm LSL #4, in=0x0000_00F1, carry_in=0, out_ready=1 -> two cycles later out_valid=1, operand=0x0000_0F10, C=0, out_tag equals in_tag.
- Immediate encodings: ASR #0 (encodes #32) in=0x8000_0000 -> 0xFFFF_FFFF, C=1. ROR #0 (RRX) in=0x0000_0001, carry_in=1 -> 0x8000_0000, C=1. LSR #0 (encodes #32) in=0x8000_0001 -> 0, C=1.
- Register boundaries, in=0x8000_0001: LSL S=32 -> 0, C=1. LSL S=33 -> 0, C=0. LSR S=200 -> 0, C=0. ROR S=64 -> 0x8000_0001, C=1. Any type S=0, carry_in=1 -> unchanged, C=1.
- Backpressure: stream 6 beats with tags 0..5 while holding out_ready=0 for 5 cycles -> in_ready drops after STAGES beats, outputs stable, then tags 0..5 emerge in order with none dropped or duplicated.
- Reset: assert rst with 2 beats in flight -> next cycle out_valid=0, operand=0, C=0; neither beat ever appears at the output.
- Width: WIDTH=16, STAGES=1, reg ROR S=20, in=0x1234 -> 0x4123, C=0, latency 1 cycle.
